pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 16-bit 5-stage pipeline.
- Detects load-use hazards, taken branches (resolved in EX), jumps (resolved in ID) and multi-cycle data-memory waits.
- Drives the PC write enable, the IF/ID stall and flush controls, and the ID/EX bubble.
- Holds a redirect FSM for multi-cycle flush windows and optional saturating performance counters.

Parameters:
REG_W, 3, register-specifier width (8 GPRs, R0 hardwired zero)
FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch (>=1)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
id_rs1  in  REG_W  ID-stage source register 1
id_rs2  in  REG_W  ID-stage source register 2
id_rs1_used  in  1  instruction in ID reads rs1
id_rs2_used  in  1  instruction in ID reads rs2
id_is_jump  in  1  jump decoded/resolved in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_W  EX-stage destination register
ex_branch_taken  in  1  branch in EX resolved taken
mem_busy  in  1  data memory not ready; back end must freeze
pc_write  out  1  PC register load enable
if_id_stall  out  1  IF/ID hold
if_id_flush  out  1  IF/ID clear to zero (NOP)
id_ex_flush  out  1  insert bubble into ID/EX
pipe_freeze  out  1  freeze ID/EX, EX/MEM, MEM/WB
ctrl_state  out  2  FSM state: 0 RUN, 1 REDIRECT, 2 FREEZE
stall_cnt  out  CNT_W  cycles with if_id_stall=1
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Control outputs are combinational from state plus inputs and take effect in the same cycle. State, counters and resume register are flops.
- Reset (async): state=RUN, redirect counter=0, resume=RUN, stall_cnt=0, flush_cnt=0. While rst=1: pc_write=0 and all other control outputs=0.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). A hazard on R0 is always ignored.
- Priority each cycle, highest first: mem_busy > ex_branch_taken > REDIRECT window > load_use > id_is_jump > normal.
- mem_busy=1 (any state):
  - Outputs: pc_write=0, if_id_stall=1, pipe_freeze=1, flushes=0.
  - Next state FREEZE. resume is captured only when entering from RUN or REDIRECT. The redirect counter holds.
- FREEZE with mem_busy=0:
  - Return to resume state; outputs are evaluated as in that state this cycle.
  - ex_branch_taken held through the freeze is acted on here.
- ex_branch_taken=1 (RUN or REDIRECT):
  - Outputs: pc_write=1, if_id_flush=1, id_ex_flush=1.
  - If FLUSH_CYCLES>1: next state REDIRECT with counter=FLUSH_CYCLES-1. Otherwise stay RUN.
- REDIRECT, no branch:
  - Outputs: pc_write=1, if_id_flush=1, id_ex_flush=1; counter decrements.
  - Leaves to RUN in the cycle the counter goes 1->0.
  - A new taken branch reloads the counter.
- load_use in RUN: pc_write=0, if_id_stall=1, id_ex_flush=1 for exactly one cycle. The resulting EX bubble clears the hazard.
- id_is_jump in RUN (no load_use): pc_write=1, if_id_flush=1, id_ex_flush=0.
- Normal operation: pc_write=1, all others 0.
- if_id_stall and if_id_flush are never both 1.
- Counters increment per qualifying cycle and saturate at all-ones; no wrap.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt and flush_cnt are implemented as above.
- Undefined: no counter flops; both outputs are constant 0.
- Control behaviour is identical either way.

Decomposition:
- Package hazard_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_REDIRECT=2'd1, ST_FREEZE=2'd2
  - REG_ZERO constant
- One sub-module, hazard_sat_counter (CNT_W, inc, clk, rst, count), instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3, id_rs2_used=1 -> one cycle of pc_write=0, if_id_stall=1, id_ex_flush=1; next cycle (ex_mem_read=0) normal; stall_cnt=1.
- R0 / unused operand: ex_rd=0 matching, or id_rs1=ex_rd with id_rs1_used=0 -> no stall.
- Branch with FLUSH_CYCLES=3: ex_branch_taken pulse -> if_id_flush=1 for 3 consecutive cycles, ctrl_state 1 for 2 cycles then 0; flush_cnt=3.
- Freeze: mem_busy high 4 cycles while in REDIRECT, counter=1 -> pipe_freeze=1 and if_id_stall=1 for 4 cycles; then one more flush cycle, then RUN.
- Priority: ex_branch_taken with simultaneous load_use and id_is_jump -> branch response only; with mem_busy also high -> freeze response only.
- Reset mid-REDIRECT: assert rst asynchronously -> ctrl_state=0, counters 0, pc_write=0 immediately; after release, normal outputs.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes and the hardwired-zero register.
// Pure constants; no logic, no latency.
package hazard_pkg;

    localparam int CTRL_STATE_W = 2;

    localparam logic [CTRL_STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [CTRL_STATE_W-1:0] ST_REDIRECT = 2'd1;
    localparam logic [CTRL_STATE_W-1:0] ST_FREEZE   = 2'd2;

    // R0 reads as zero, so a producer targeting it never creates a real dependency
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush controls and perf counters out.
// master = pipeline side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic [REG_W-1:0]        id_rs1;
    logic [REG_W-1:0]        id_rs2;
    logic                    id_rs1_used;
    logic                    id_rs2_used;
    logic                    id_is_jump;
    logic                    ex_mem_read;
    logic [REG_W-1:0]        ex_rd;
    logic                    ex_branch_taken;
    logic                    mem_busy;

    logic                    pc_write;
    logic                    if_id_stall;
    logic                    if_id_flush;
    logic                    id_ex_flush;
    logic                    pipe_freeze;
    logic [CTRL_STATE_W-1:0] ctrl_state;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_jump,
               ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
        input  pc_write, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze,
               ctrl_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_jump,
               ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
        output pc_write, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze,
               ctrl_state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_sat_counter.sv
// Event counter that saturates at all-ones; count updates one cycle after inc.
// No backpressure: inc is sampled every cycle.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             inc,
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: controls are combinational (same-cycle), FSM/counters registered; HAZARD_PERF_CNT_EN adds perf counters.
// mem_busy freezes the back end and holds IF/ID; nothing else is ever back-pressured.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W        = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int                RCNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
    localparam bit                MULTI_FLUSH = (FLUSH_CYCLES > 1);

    logic [CTRL_STATE_W-1:0] state;
    logic [CTRL_STATE_W-1:0] state_nxt;
    logic [CTRL_STATE_W-1:0] resume;
    logic [CTRL_STATE_W-1:0] resume_nxt;
    logic [CTRL_STATE_W-1:0] eff_state;
    logic [RCNT_W-1:0]       rcnt;
    logic [RCNT_W-1:0]       rcnt_nxt;
    logic                    rs1_hit;
    logic                    rs2_hit;
    logic                    load_use;
    logic                    redirect_now;

    assign rs1_hit  = hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit  = hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd);
    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_W'(REG_ZERO)) && (rs1_hit || rs2_hit);

    // Leaving FREEZE behaves exactly like the state that was interrupted
    assign eff_state    = (state == ST_FREEZE) ? resume : state;
    assign redirect_now = hz.ex_branch_taken || (eff_state == ST_REDIRECT);

    always_comb begin
        state_nxt  = state;
        resume_nxt = resume;
        rcnt_nxt   = rcnt;
        if (hz.mem_busy) begin
            state_nxt = ST_FREEZE;
            if (state != ST_FREEZE) begin
                resume_nxt = state;
            end
        end else if (hz.ex_branch_taken) begin
            if (MULTI_FLUSH) begin
                state_nxt = ST_REDIRECT;
                rcnt_nxt  = RCNT_RELOAD;
            end else begin
                state_nxt = ST_RUN;
            end
        end else if (eff_state == ST_REDIRECT) begin
            rcnt_nxt  = rcnt - RCNT_ONE;
            state_nxt = (rcnt == RCNT_ONE) ? ST_RUN : ST_REDIRECT;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            resume <= ST_RUN;
            rcnt   <= '0;
        end else begin
            state  <= state_nxt;
            resume <= resume_nxt;
            rcnt   <= rcnt_nxt;
        end
    end

    always_comb begin
        hz.pc_write    = 1'b0;
        hz.if_id_stall = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.pipe_freeze = 1'b0;
        if (!rst) begin
            if (hz.mem_busy) begin
                hz.if_id_stall = 1'b1;
                hz.pipe_freeze = 1'b1;
            end else if (redirect_now) begin
                hz.pc_write    = 1'b1;
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use) begin
                // The bubble moves the load out of EX, so the hazard self-clears next cycle
                hz.if_id_stall = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (hz.id_is_jump) begin
                hz.pc_write    = 1'b1;
                hz.if_id_flush = 1'b1;
            end else begin
                hz.pc_write    = 1'b1;
            end
        end
    end

    assign hz.ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .inc   (hz.if_id_stall),
        .clk   (clk),
        .rst   (rst),
        .count (hz.stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .inc   (hz.if_id_flush),
        .clk   (clk),
        .rst   (rst),
        .count (hz.flush_cnt)
    );
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks plus randomized traffic against a flush-window model.
module tb_pipeline_hazard_ctrl;

    localparam int RW   = 3;
    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_hazard_ctrl_if #(.REG_W(RW), .CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.REG_W(RW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: remaining flush-window cycles after the current one, plus a frozen flag
    int m_rem    = 0;
    bit m_frozen = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    // {pc_write, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze}
    function automatic logic [4:0] model_ctl();
        bit lu;
        lu = bus.ex_mem_read && (bus.ex_rd != 0) &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        if (bus.mem_busy)                       return 5'b01001;
        if (bus.ex_branch_taken || m_rem > 0)   return 5'b10110;
        if (lu)                                 return 5'b01010;
        if (bus.id_is_jump)                     return 5'b10100;
        return 5'b10000;
    endfunction

    logic [4:0] upd_ctl;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem    <= 0;
            m_frozen <= 1'b0;
            m_stall  <= 0;
            m_flush  <= 0;
        end else begin
            upd_ctl = model_ctl();
            if (upd_ctl[3] && m_stall < MAXC) m_stall <= m_stall + 1;
            if (upd_ctl[2] && m_flush < MAXC) m_flush <= m_flush + 1;
            if (bus.mem_busy) begin
                m_frozen <= 1'b1;
            end else begin
                m_frozen <= 1'b0;
                if (bus.ex_branch_taken) m_rem <= FC - 1;
                else if (m_rem > 0)      m_rem <= m_rem - 1;
            end
        end
    end

    logic [4:0] e_ctl;
    int         e_st;
    always @(negedge clk) begin
        if (rst) begin
            e_ctl = 5'b0;
            e_st  = 0;
        end else begin
            e_ctl = model_ctl();
            e_st  = m_frozen ? 2 : ((m_rem > 0) ? 1 : 0);
        end
        chk("pc_write",    bus.pc_write,    e_ctl[4]);
        chk("if_id_stall", bus.if_id_stall, e_ctl[3]);
        chk("if_id_flush", bus.if_id_flush, e_ctl[2]);
        chk("id_ex_flush", bus.id_ex_flush, e_ctl[1]);
        chk("pipe_freeze", bus.pipe_freeze, e_ctl[0]);
        chk("ctrl_state",  bus.ctrl_state,  e_st);
        chk("stall_cnt",   bus.stall_cnt,   PERF ? m_stall : 0);
        chk("flush_cnt",   bus.flush_cnt,   PERF ? m_flush : 0);
    end

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input bit jmp,
                          input bit mrd, input int rd, input bit br, input bit busy);
        bus.id_rs1          = 3'(rs1);
        bus.id_rs2          = 3'(rs2);
        bus.id_rs1_used     = u1;
        bus.id_rs2_used     = u2;
        bus.id_is_jump      = jmp;
        bus.ex_mem_read     = mrd;
        bus.ex_rd           = 3'(rd);
        bus.ex_branch_taken = br;
        bus.mem_busy        = busy;
    endtask

    // Apply inputs, then settle just past the falling edge for literal checks
    task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2, input bit jmp,
                         input bit mrd, input int rd, input bit br, input bit busy);
        set_in(rs1, rs2, u1, u2, jmp, mrd, rd, br, busy);
        @(negedge clk); #1;
    endtask

    task automatic fin();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_pc_write",  bus.pc_write, 0);
        chk("rst_state",     bus.ctrl_state, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        chk("run_pc_write", bus.pc_write, 1);
        chk("run_flush",    bus.if_id_flush, 0);
        fin();

        // Load-use on rs2
        drive(0, 3, 0, 1, 0, 1, 3, 0, 0);
        chk("lu_pc_write", bus.pc_write, 0);
        chk("lu_stall",    bus.if_id_stall, 1);
        chk("lu_idex",     bus.id_ex_flush, 1);
        fin();
        drive(0, 3, 0, 1, 0, 0, 3, 0, 0);
        chk("lu_after_pc_write", bus.pc_write, 1);
        chk("lu_after_stall",    bus.if_id_stall, 0);
        chk("lu_stall_cnt",      bus.stall_cnt, PERF ? 1 : 0);
        fin();

        // R0 destination and unused operand never stall
        drive(0, 0, 1, 1, 0, 1, 0, 0, 0);
        chk("r0_stall", bus.if_id_stall, 0);
        fin();
        drive(5, 2, 0, 1, 0, 1, 5, 0, 0);
        chk("unused_stall", bus.if_id_stall, 0);
        fin();

        // Branch pulse, three-cycle flush window
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("br0_flush", bus.if_id_flush, 1);
        chk("br0_state", bus.ctrl_state, 0);
        fin();
        idle();
        chk("br1_flush", bus.if_id_flush, 1);
        chk("br1_state", bus.ctrl_state, 1);
        fin();
        idle();
        chk("br2_flush", bus.if_id_flush, 1);
        chk("br2_state", bus.ctrl_state, 1);
        fin();
        idle();
        chk("br3_flush",     bus.if_id_flush, 0);
        chk("br3_state",     bus.ctrl_state, 0);
        chk("br_flush_cnt",  bus.flush_cnt, PERF ? 3 : 0);
        fin();

        // Freeze for 4 cycles in REDIRECT with one flush cycle left
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        fin();
        idle();
        fin();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("frz_freeze", bus.pipe_freeze, 1);
            chk("frz_stall",  bus.if_id_stall, 1);
            chk("frz_flush",  bus.if_id_flush, 0);
            fin();
        end
        idle();
        chk("frz_exit_flush", bus.if_id_flush, 1);
        chk("frz_exit_state", bus.ctrl_state, 2);
        fin();
        idle();
        chk("frz_run_state", bus.ctrl_state, 0);
        chk("frz_run_flush", bus.if_id_flush, 0);
        chk("frz_stall_cnt", bus.stall_cnt, PERF ? 5 : 0);
        chk("frz_flush_cnt", bus.flush_cnt, PERF ? 6 : 0);
        fin();

        // Priority: branch over load-use and jump, then mem_busy over everything
        drive(3, 0, 1, 0, 1, 1, 3, 1, 0);
        chk("pri_br_pcw",   bus.pc_write, 1);
        chk("pri_br_stall", bus.if_id_stall, 0);
        chk("pri_br_idex",  bus.id_ex_flush, 1);
        fin();
        for (int i = 0; i < 2; i++) begin
            idle();
            fin();
        end
        drive(3, 0, 1, 0, 1, 1, 3, 1, 1);
        chk("pri_busy_pcw",   bus.pc_write, 0);
        chk("pri_busy_flush", bus.if_id_flush, 0);
        chk("pri_busy_idex",  bus.id_ex_flush, 0);
        fin();
        drive(3, 0, 1, 0, 1, 1, 3, 1, 0);
        chk("pri_held_br_flush", bus.if_id_flush, 1);
        chk("pri_held_br_state", bus.ctrl_state, 2);
        fin();
        for (int i = 0; i < 3; i++) begin
            idle();
            fin();
        end

        // Asynchronous reset in the middle of a flush window
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        fin();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state",     bus.ctrl_state, 0);
        chk("arst_pc_write",  bus.pc_write, 0);
        chk("arst_flush",     bus.if_id_flush, 0);
        chk("arst_stall_cnt", bus.stall_cnt, 0);
        chk("arst_flush_cnt", bus.flush_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        chk("post_rst_pcw",   bus.pc_write, 1);
        chk("post_rst_state", bus.ctrl_state, 0);
        fin();

        // Stall counter saturation
        for (int i = 0; i < MAXC + 5; i++) begin
            drive(0, 3, 0, 1, 0, 1, 3, 0, 0);
            fin();
        end
        idle();
        chk("sat_stall_cnt", bus.stall_cnt, PERF ? MAXC : 0);
        fin();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            set_in($urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 45),
                   $urandom_range(0, 7), ($urandom_range(0, 99) < 8),
                   ($urandom_range(0, 99) < 12));
            fin();
        end
        rst = 1'b0;
        idle();
        fin();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
